ip_bus_arbiter: RTL and testbench
=================================

# ip_bus_arbiter

- Shares the internal MSX-50BUS between two requesters:
  - m0: the cartridge-edge front-end.
  - m1: an internal master, such as a ROM loader or debug port.
- Serialises their transactions onto the single bus strobe set and gathers slave read responses, including the extended-slot register at FFFFh.
- Unanswered reads complete with open-bus data after a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 16: wait-state cycles allowed for `bus_read_ready` before a read completes as open bus (legal range 1–255).
- `clk` input, 1 bit: system clock; everything is sampled on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `m0_req`, `m1_req` input, 1 bit each: request; held high until the matching ack.
- `m0_write`, `m1_write` input, 1 bit each: 1 = write, 0 = read.
- `m0_io`, `m1_io` input, 1 bit each: 1 = I/O space, 0 = memory space.
- `m0_address`, `m1_address` input, 16 bits each: transaction address.
- `m0_wdata`, `m1_wdata` input, 8 bits each: write data.
- `m0_ack`, `m1_ack` output, 1 bit each: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` output, 8 bits each: read result, valid with ack and held until that master's next ack.
- `bus_address` output, 16 bits; `bus_write_data` output, 8 bits.
- `bus_read`, `bus_write` output, 1 bit each: one-cycle strobes.
- `bus_io`, `bus_memory` output, 1 bit each: space qualifiers, held for the whole transaction.
- `bus_read_ready` input, 1 bit; `bus_read_data` input, 8 bits: OR-combined slave response.
- `timeout` output, 1 bit: one-cycle pulse when a read ends without a ready.

## Operation
- States:
  - IDLE: no transaction; samples `m0_req`/`m1_req`.
  - ISSUE: drives the bus strobe for one cycle.
  - WAIT: read only; waits for `bus_read_ready` or timeout.
  - DONE: pulses the granted master's ack.
- Reset values: state = IDLE, every output 0, `last_grant` = m1 (so m0 wins the first tie).
- Transitions:
  - IDLE → ISSUE when any request is high.
  - ISSUE → DONE for a write; ISSUE → WAIT for a read.
  - WAIT → DONE on `bus_read_ready` = 1, or when the wait counter reaches `TIMEOUT_CYCLES`.
  - DONE → IDLE always.
- Arbitration, in IDLE only:
  - A single requester is granted.
  - When both request, the one not equal to `last_grant` wins (round-robin).
  - `last_grant` updates on grant.
- Latched on grant, and held from ISSUE through WAIT: address, write data, io/memory and write/read of the granted master.
- Strobes: in ISSUE, `bus_read` = ~write and `bus_write` = write. `bus_io` = io and `bus_memory` = ~io in ISSUE and WAIT, 0 elsewhere.
- Read capture:
  - The first WAIT cycle with `bus_read_ready` = 1 latches `bus_read_data`.
  - On timeout, the latched value is 8'hFF and `timeout` pulses in DONE.
- Wait counter: cleared on entering WAIT, incremented each WAIT cycle without ready; counter width is 8 bits.
- Write ack: `mN_rdata` is left unchanged.
- Ignored inputs:
  - `bus_read_ready` outside WAIT.
  - Requests outside IDLE, including a losing requester; it stays pending and is granted at the next IDLE.
- Requester rule: drop `req` the cycle after ack; a `req` still high in the following IDLE is a new transaction.
- Reset mid-transaction: the FSM returns to IDLE at once, no ack is issued, strobes drop asynchronously, and the requester must re-present.

## Timing
- Request sampled in IDLE at cycle T.
- Bus strobe is high during T+1 (ISSUE).
- Write: ack at T+2.
- Read with a slave answering one cycle after the strobe (`bus_read_ready` high at T+2): ack and data at T+3.
- Read with ready at T+1+k (k ≥ 1): ack at T+2+k.
- Timeout: WAIT occupies T+2 through T+1+`TIMEOUT_CYCLES`, then ack, data FFh and `timeout` at T+2+`TIMEOUT_CYCLES`.
- Next grant: at the earliest in the IDLE one cycle after DONE. Back-to-back write throughput is one transaction per 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `ip_bus_arbiter_pkg`:
  - State encoding: IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3.
  - `OPEN_BUS_DATA` = 8'hFF.
  - `GRANT_M0` = 0 and `GRANT_M1` = 1.
- One sub-module, `ip_bus_wait_timer`, holds the wait counter plus the ready/timeout decision. Inputs: `clk`, `reset`, `start`, `ready`. Outputs: `done`, `expired`.
- Arbitration, latching and the FSM stay in the top level.

## Test plan
- m0 writes memory FFFFh with A5h, m1 idle → `bus_write` and `bus_memory` at T+1 with `bus_address` FFFFh and data A5h; `m0_ack` at T+2; `m0_rdata` unchanged.
- m1 reads memory FFFFh; model slave asserts ready at T+2 with 5Ah → `m1_ack` at T+3, `m1_rdata` = 5Ah, `timeout` stays 0.
- m0 and m1 raise req in the same cycle, three times in a row → grants go m0, m1, m0; no dropped or duplicated acks.
- m0 I/O read of 0098h, no slave answers, `TIMEOUT_CYCLES` = 4 → `bus_io` held T+1..T+5; ack, `m0_rdata` = FFh and `timeout` at T+6.
- Reset asserted during WAIT of an m1 read → all outputs 0 immediately, no `m1_ack`. After release, m1 still requesting → a fresh ISSUE follows.
- `bus_read_ready` pulsed during IDLE and during a write's DONE → ignored; no spurious ack or rdata change.

Source files
------------

// File: rtl/ip_bus_arbiter_pkg.sv
// Shared types and constants for the MSX-50BUS arbiter slice.
package ip_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_M0 = 1'b0,
        GRANT_M1 = 1'b1
    } grant_t;

    localparam logic [DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Round-robin pick: on a tie the master that did not win last time goes first.
    function automatic grant_t pick_grant(logic m0_req, logic m1_req, grant_t last_grant);
        if (m0_req && m1_req) begin
            return (last_grant == GRANT_M1) ? GRANT_M0 : GRANT_M1;
        end else if (m1_req) begin
            return GRANT_M1;
        end
        return GRANT_M0;
    endfunction

endpackage

// File: rtl/ip_bus_arbiter_if.sv
// Requester handshakes and the shared bus strobe set of the arbiter.
interface ip_bus_arbiter_if;
    import ip_bus_arbiter_pkg::*;

    logic              m0_req;
    logic              m0_write;
    logic              m0_io;
    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_write;
    logic              m1_io;
    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_read;
    logic              bus_write;
    logic              bus_io;
    logic              bus_memory;
    logic              bus_read_ready;
    logic [DATA_W-1:0] bus_read_data;
    logic              timeout;

    // master: the arbiter's view; slave: requesters plus the bus slaves
    modport master (
        input  m0_req, m0_write, m0_io, m0_address, m0_wdata,
        input  m1_req, m1_write, m1_io, m1_address, m1_wdata,
        input  bus_read_ready, bus_read_data,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output bus_address, bus_write_data, bus_read, bus_write,
        output bus_io, bus_memory, timeout
    );

    modport slave (
        output m0_req, m0_write, m0_io, m0_address, m0_wdata,
        output m1_req, m1_write, m1_io, m1_address, m1_wdata,
        output bus_read_ready, bus_read_data,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  bus_address, bus_write_data, bus_read, bus_write,
        input  bus_io, bus_memory, timeout
    );

endinterface

// File: rtl/ip_bus_wait_timer.sv
// Read wait-state counter: finishes a read on slave ready or after TIMEOUT_CYCLES waits.
module ip_bus_wait_timer
    import ip_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ready,
    output logic done,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             running;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (running) begin
            if (ready || (count == LAST_WAIT)) begin
                running <= 1'b0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Ready wins over expiry when both land on the last wait cycle.
    always_comb begin
        done    = running && ready;
        expired = running && !ready && (count == LAST_WAIT);
    end

endmodule

// File: rtl/ip_bus_arbiter.sv
// Two-master arbiter for the MSX-50BUS: grants, issues strobes and returns read data or open bus.
module ip_bus_arbiter
    import ip_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    ip_bus_arbiter_if.master bus
);

    state_t            state;
    grant_t            grant;
    grant_t            last_grant;
    logic              cur_write;

    grant_t            next_grant_c;
    bus_req_t          sel_c;
    logic              start_c;
    logic [DATA_W-1:0] read_data_c;
    logic              wait_done;
    logic              wait_expired;

    always_comb begin
        next_grant_c = pick_grant(bus.m0_req, bus.m1_req, last_grant);
        if (next_grant_c == GRANT_M0) begin
            sel_c.write   = bus.m0_write;
            sel_c.io      = bus.m0_io;
            sel_c.address = bus.m0_address;
            sel_c.wdata   = bus.m0_wdata;
        end else begin
            sel_c.write   = bus.m1_write;
            sel_c.io      = bus.m1_io;
            sel_c.address = bus.m1_address;
            sel_c.wdata   = bus.m1_wdata;
        end
        start_c     = (state == ISSUE) && !cur_write;
        read_data_c = wait_done ? bus.bus_read_data : OPEN_BUS_DATA;
    end

    ip_bus_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (start_c),
        .ready  (bus.bus_read_ready),
        .done   (wait_done),
        .expired(wait_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            grant              <= GRANT_M0;
            last_grant         <= GRANT_M1;
            cur_write          <= 1'b0;
            bus.m0_ack         <= 1'b0;
            bus.m1_ack         <= 1'b0;
            bus.m0_rdata       <= '0;
            bus.m1_rdata       <= '0;
            bus.bus_address    <= '0;
            bus.bus_write_data <= '0;
            bus.bus_read       <= 1'b0;
            bus.bus_write      <= 1'b0;
            bus.bus_io         <= 1'b0;
            bus.bus_memory     <= 1'b0;
            bus.timeout        <= 1'b0;
        end else begin
            bus.m0_ack    <= 1'b0;
            bus.m1_ack    <= 1'b0;
            bus.bus_read  <= 1'b0;
            bus.bus_write <= 1'b0;
            bus.timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        state              <= ISSUE;
                        grant              <= next_grant_c;
                        last_grant         <= next_grant_c;
                        cur_write          <= sel_c.write;
                        bus.bus_address    <= sel_c.address;
                        bus.bus_write_data <= sel_c.wdata;
                        bus.bus_read       <= !sel_c.write;
                        bus.bus_write      <= sel_c.write;
                        bus.bus_io         <= sel_c.io;
                        bus.bus_memory     <= !sel_c.io;
                    end
                end
                ISSUE: begin
                    if (cur_write) begin
                        state          <= DONE;
                        bus.m0_ack     <= (grant == GRANT_M0);
                        bus.m1_ack     <= (grant == GRANT_M1);
                        bus.bus_io     <= 1'b0;
                        bus.bus_memory <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_done || wait_expired) begin
                        state          <= DONE;
                        bus.timeout    <= wait_expired;
                        bus.bus_io     <= 1'b0;
                        bus.bus_memory <= 1'b0;
                        if (grant == GRANT_M0) begin
                            bus.m0_ack   <= 1'b1;
                            bus.m0_rdata <= read_data_c;
                        end else begin
                            bus.m1_ack   <= 1'b1;
                            bus.m1_rdata <= read_data_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_bus_arbiter.sv
// Scoreboard bench for ip_bus_arbiter: random two-master traffic against an address-keyed slave model.
module tb_ip_bus_arbiter;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ip_bus_arbiter_if ifc();

    ip_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        bit          write;
        bit          io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          tmo;
        int          lat;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [7:0]  model_rdata[2];
    int          model_last;
    int          noise_mode;

    bit          r_use[2];
    bit          r_wr[2];
    bit          r_io[2];
    logic [15:0] r_addr[2];
    logic [7:0]  r_data[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Slave model: I/O ports x9x never answer; others answer after 1..4 waits with a hashed byte.
    function automatic bit slave_answers(bit io, logic [15:0] a);
        return !(io && (a[7:4] == 4'h9));
    endfunction

    function automatic int slave_latency(logic [15:0] a);
        logic [1:0] inv;
        inv = ~a[1:0];
        return 1 + int'(inv);
    endfunction

    function automatic logic [7:0] slave_data(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic exp_t predict(int m);
        exp_t e;
        e.m = m; e.write = r_wr[m]; e.io = r_io[m]; e.addr = r_addr[m]; e.wdata = r_data[m];
        if (r_wr[m]) begin
            e.rdata = model_rdata[m]; e.tmo = 1'b0; e.lat = 1;
        end else if (slave_answers(r_io[m], r_addr[m])) begin
            e.rdata = slave_data(r_addr[m]); e.tmo = 1'b0; e.lat = 1 + slave_latency(r_addr[m]);
        end else begin
            e.rdata = 8'hFF; e.tmo = 1'b1; e.lat = 1 + int'(TO);
        end
        model_rdata[m] = e.rdata;
        return e;
    endfunction

    task automatic set_master(int m, bit req);
        if (m == 0) begin
            ifc.m0_req = req; ifc.m0_write = r_wr[0]; ifc.m0_io = r_io[0];
            ifc.m0_address = r_addr[0]; ifc.m0_wdata = r_data[0];
        end else begin
            ifc.m1_req = req; ifc.m1_write = r_wr[1]; ifc.m1_io = r_io[1];
            ifc.m1_address = r_addr[1]; ifc.m1_wdata = r_data[1];
        end
    endtask

    task automatic wait_ack(int m);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m == 0) ? ifc.m0_ack : ifc.m1_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check($sformatf("ack_wait_m%0d", m), 32'd0, 32'd1);
        if (m == 0) ifc.m0_req = 1'b0; else ifc.m1_req = 1'b0;
    endtask

    task automatic do_round();
        int first;
        int second;
        if (r_use[0] && r_use[1]) begin
            first  = (model_last == 1) ? 0 : 1;
            second = 1 - first;
            exp_q.push_back(predict(first));
            exp_q.push_back(predict(second));
            model_last = second;
        end else begin
            first = r_use[0] ? 0 : 1;
            exp_q.push_back(predict(first));
            model_last = first;
        end
        for (int m = 0; m < 2; m++) if (r_use[m]) set_master(m, 1'b1);
        fork
            begin if (r_use[0]) wait_ack(0); end
            begin if (r_use[1]) wait_ack(1); end
        join
        @(negedge clk);
    endtask

    task automatic set_txn(int m, bit wr, bit io, logic [15:0] a, logic [7:0] d);
        r_wr[m] = wr; r_io[m] = io; r_addr[m] = a; r_data[m] = d;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_acks"}, {ifc.m0_ack, ifc.m1_ack, ifc.timeout}, 32'd0);
        check({tag, "_rdata"}, {ifc.m0_rdata, ifc.m1_rdata}, 32'd0);
        check({tag, "_strobes"}, {ifc.bus_read, ifc.bus_write, ifc.bus_io, ifc.bus_memory}, 32'd0);
        check({tag, "_bus"}, {ifc.bus_address, ifc.bus_write_data}, 32'd0);
    endtask

    // Slave responder plus optional ready noise outside of active transactions.
    initial begin
        int cnt;
        logic [7:0] pdata;
        cnt = 0;
        pdata = '0;
        ifc.bus_read_ready = 1'b0;
        ifc.bus_read_data  = '0;
        forever begin
            @(negedge clk);
            ifc.bus_read_ready = 1'b0;
            ifc.bus_read_data  = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.bus_read_ready = 1'b1;
                    ifc.bus_read_data  = pdata;
                end
            end else if (ifc.bus_read && !reset) begin
                if (slave_answers(ifc.bus_io, ifc.bus_address)) begin
                    cnt   = slave_latency(ifc.bus_address);
                    pdata = slave_data(ifc.bus_address);
                end
            end else if (!ifc.bus_io && !ifc.bus_memory && noise_mode != 0 &&
                         (noise_mode == 2 || $urandom_range(0, 3) == 0)) begin
                ifc.bus_read_ready = 1'b1;
                ifc.bus_read_data  = 8'($urandom);
            end
        end
    end

    // Monitor: matches strobes and acks against the expected-transaction queue.
    initial begin
        int cyc;
        int strobe_cyc;
        bit in_txn;
        bit ack_any;
        exp_t cur;
        exp_t e;
        logic [7:0] held[2];
        cyc = 0; strobe_cyc = 0; in_txn = 1'b0;
        held[0] = '0; held[1] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_txn = 1'b0;
                held[0] = '0; held[1] = '0;
            end else begin
                ack_any = ifc.m0_ack || ifc.m1_ack;
                if (ifc.bus_read || ifc.bus_write) begin
                    if (exp_q.size() == 0) begin
                        check("strobe_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q[0];
                        check("strobe_write", ifc.bus_write, cur.write);
                        check("strobe_read", ifc.bus_read, !cur.write);
                        check("bus_address", ifc.bus_address, cur.addr);
                        check("bus_space", {ifc.bus_io, ifc.bus_memory}, {cur.io, !cur.io});
                        if (cur.write) check("bus_write_data", ifc.bus_write_data, cur.wdata);
                        strobe_cyc = cyc;
                        in_txn = 1'b1;
                    end
                end else if (in_txn && !ack_any) begin
                    check("space_held", {ifc.bus_io, ifc.bus_memory}, {cur.io, !cur.io});
                end
                if (ack_any) begin
                    check("dual_ack", {ifc.m0_ack, ifc.m1_ack}, {ifc.m0_ack, 1'b0} | {1'b0, !ifc.m0_ack});
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_master", ifc.m1_ack ? 32'd1 : 32'd0, e.m);
                        check("ack_rdata", (e.m == 0) ? ifc.m0_rdata : ifc.m1_rdata, e.rdata);
                        check("ack_timeout", ifc.timeout, e.tmo);
                        check("ack_latency", cyc - strobe_cyc, e.lat);
                        check("space_released", {ifc.bus_io, ifc.bus_memory}, 32'd0);
                        held[e.m] = e.rdata;
                    end
                    in_txn = 1'b0;
                end else begin
                    check("timeout_spurious", ifc.timeout, 32'd0);
                end
                if (!ifc.m0_ack) check("m0_rdata_hold", ifc.m0_rdata, held[0]);
                if (!ifc.m1_ack) check("m1_rdata_hold", ifc.m1_rdata, held[1]);
            end
        end
    end

    initial begin
        bit seen;
        ifc.m0_req = 0; ifc.m0_write = 0; ifc.m0_io = 0; ifc.m0_address = '0; ifc.m0_wdata = '0;
        ifc.m1_req = 0; ifc.m1_write = 0; ifc.m1_io = 0; ifc.m1_address = '0; ifc.m1_wdata = '0;
        model_rdata[0] = '0; model_rdata[1] = '0;
        model_last = 1;
        noise_mode = 0;
        r_use[0] = 0; r_use[1] = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 reset = 1'b0;
        @(negedge clk);

        // m0 memory write FFFFh <- A5h
        r_use[0] = 1; r_use[1] = 0; set_txn(0, 1, 0, 16'hFFFF, 8'hA5);
        do_round();
        // m1 memory read FFFFh, slave answers 5Ah one cycle after the strobe
        r_use[0] = 0; r_use[1] = 1; set_txn(1, 0, 0, 16'hFFFF, 8'h00);
        do_round();
        // Simultaneous requests, three rounds
        for (int i = 0; i < 3; i++) begin
            r_use[0] = 1; r_use[1] = 1;
            set_txn(0, 1, 0, 16'h4000 + 16'(i), 8'(i + 1));
            set_txn(1, 0, 0, 16'h8002 + 16'(i), 8'h00);
            do_round();
        end
        // m0 I/O read of 0098h with no slave: open bus after TO waits
        r_use[0] = 1; r_use[1] = 0; set_txn(0, 0, 1, 16'h0098, 8'h00);
        do_round();

        // Reset during WAIT of an m1 read; m1 keeps requesting afterwards
        r_use[0] = 0; r_use[1] = 1; set_txn(1, 0, 1, 16'h0094, 8'h00);
        exp_q.push_back(predict(1));
        set_master(1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = ifc.bus_read;
        end
        check("reset_test_strobe", seen, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        exp_q.delete();
        model_rdata[0] = '0; model_rdata[1] = '0;
        model_last = 1;
        @(negedge clk);
        #2 reset = 1'b0;
        exp_q.push_back(predict(1));
        model_last = 1;
        wait_ack(1);
        @(negedge clk);

        // Ready noise during IDLE and during a write's DONE
        noise_mode = 2;
        r_use[0] = 1; r_use[1] = 0; set_txn(0, 1, 0, 16'h1234, 8'h77);
        do_round();
        repeat (4) @(negedge clk);
        noise_mode = 0;

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            noise_mode = $urandom_range(0, 1);
            for (int m = 0; m < 2; m++) begin
                r_use[m] = 1'($urandom_range(0, 1));
                r_addr[m] = 16'($urandom);
                r_io[m] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0) r_addr[m][7:4] = 4'h9;
                r_wr[m] = 1'($urandom_range(0, 1));
                r_data[m] = 8'($urandom);
            end
            if (!r_use[0] && !r_use[1]) r_use[$urandom_range(0, 1)] = 1'b1;
            do_round();
        end
        noise_mode = 0;

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
